mem_copy_engine: RTL and testbench



---
 rtl/mem_copy_engine_if.sv | 31 +++
 rtl/mem_copy_engine.sv | 137 +++++++++++++
 tb/tb_mem_copy_engine.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/mem_copy_engine_if.sv
// mem_copy_engine_if
//   Bundles the copy-command strobe and the data-memory port of the copy engine.
//   master : the copy engine
//            inputs  start, src_addr, dst_addr, len, mem_dat_out
//            outputs busy, done, mem_addr, mem_wr_en, mem_dat_in
//   slave  : the control path and memory side, with each direction reversed
interface mem_copy_engine_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          start;
  logic [AW-1:0] src_addr;
  logic [AW-1:0] dst_addr;
  logic [7:0]    len;
  logic          busy;
  logic          done;
  logic [AW-1:0] mem_addr;
  logic          mem_wr_en;
  logic [DW-1:0] mem_dat_in;
  logic [DW-1:0] mem_dat_out;

  modport master (
    input  start, src_addr, dst_addr, len, mem_dat_out,
    output busy, done, mem_addr, mem_wr_en, mem_dat_in
  );

  modport slave (
    output start, src_addr, dst_addr, len, mem_dat_out,
    input  busy, done, mem_addr, mem_wr_en, mem_dat_in
  );
endinterface

// File: rtl/mem_copy_engine.sv
// mem_copy_engine
//   Copies len bytes from src_addr to dst_addr within a single data memory.
//   Each byte takes two cycles: a read cycle, then a write cycle. A single
//   done pulse follows the last write. len = 0 goes directly to DONE.
//   Ports:
//     clk    clock, rising edge
//     rst_n  asynchronous active-low reset; aborts a copy in progress
//     bus    mem_copy_engine_if.master (command inputs, busy/done, memory port)
//   Optional build macro:
//     COPY_OVERLAP_SAFE_EN - when dst_addr > src_addr, copy from the top of the
//                            block downward so that overlapping moves behave
//                            like memmove.
module mem_copy_engine #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mem_copy_engine_if.master    bus
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

  state_t        r_state;
  logic [AW-1:0] r_src_ptr;
  logic [AW-1:0] r_dst_ptr;
  logic [7:0]    r_cnt;
  logic [DW-1:0] r_buf;
  logic          r_busy;
  logic          r_done;
  logic [AW-1:0] r_mem_addr;
  logic          r_mem_wr_en;

  logic [AW-1:0] w_src_first;
  logic [AW-1:0] w_dst_first;
  logic [AW-1:0] w_src_nxt;
  logic [AW-1:0] w_dst_nxt;

`ifdef COPY_OVERLAP_SAFE_EN
  logic          r_bwd;
  logic          w_bwd;
  // A destination above the source could overwrite bytes that have not yet
  // been read, so start at the top of the block and walk downward.
  assign w_bwd       = (bus.dst_addr > bus.src_addr);
  assign w_src_first = w_bwd ? bus.src_addr + AW'(bus.len) - AW'(1) : bus.src_addr;
  assign w_dst_first = w_bwd ? bus.dst_addr + AW'(bus.len) - AW'(1) : bus.dst_addr;
  assign w_src_nxt   = r_bwd ? r_src_ptr - AW'(1) : r_src_ptr + AW'(1);
  assign w_dst_nxt   = r_bwd ? r_dst_ptr - AW'(1) : r_dst_ptr + AW'(1);
`else
  assign w_src_first = bus.src_addr;
  assign w_dst_first = bus.dst_addr;
  assign w_src_nxt   = r_src_ptr + AW'(1);
  assign w_dst_nxt   = r_dst_ptr + AW'(1);
`endif

  // Write data is decoded from the buffer and state, so it is zero outside WR.
  assign bus.mem_dat_in = (r_state == S_WR) ? r_buf : '0;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wr_en  = r_mem_wr_en;

  // Outputs are registered. Each branch loads the output values for the state
  // being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_src_ptr   <= '0;
      r_dst_ptr   <= '0;
      r_cnt       <= '0;
      r_buf       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wr_en <= 1'b0;
`ifdef COPY_OVERLAP_SAFE_EN
      r_bwd       <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_busy <= 1'b1;
            if (bus.len != 8'd0) begin
              r_state    <= S_RD;
              r_src_ptr  <= w_src_first;
              r_dst_ptr  <= w_dst_first;
              r_cnt      <= bus.len;
              r_mem_addr <= w_src_first;
`ifdef COPY_OVERLAP_SAFE_EN
              r_bwd      <= w_bwd;
`endif
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        S_RD: begin
          r_buf       <= bus.mem_dat_out;
          r_src_ptr   <= w_src_nxt;
          r_state     <= S_WR;
          r_mem_addr  <= r_dst_ptr;
          r_mem_wr_en <= 1'b1;
        end
        S_WR: begin
          r_dst_ptr   <= w_dst_nxt;
          r_cnt       <= r_cnt - 8'd1;
          r_mem_wr_en <= 1'b0;
          if (r_cnt == 8'd1) begin
            r_state    <= S_DONE;
            r_done     <= 1'b1;
            r_mem_addr <= '0;
          end else begin
            r_state    <= S_RD;
            r_mem_addr <= r_src_ptr;  // already advanced during RD
          end
        end
        S_DONE: begin
          r_state     <= S_IDLE;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
          r_mem_addr  <= '0;
          r_mem_wr_en <= 1'b0;
        end
        default: begin
          r_state     <= S_IDLE;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
          r_mem_addr  <= '0;
          r_mem_wr_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// tb_mem_copy_engine
//   Directed test of mem_copy_engine with a behavioural 256x8 memory:
//   reset, basic copy, len=0, address wrap, ignored restart, mid-copy abort,
//   and overlapping regions.
module tb_mem_copy_engine;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_copy_engine_if #(.AW(8), .DW(8)) bus ();

  mem_copy_engine #(.AW(8), .DW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural memory: combinational read, write on the rising edge.
  logic [7:0] mem [256];
  assign bus.mem_dat_out = mem[bus.mem_addr];
  always @(posedge clk) if (bus.mem_wr_en) mem[bus.mem_addr] = bus.mem_dat_in;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Monitor, sampled on the falling edge
  int t0;
  int wr_cnt, busy_cnt, done_cnt, done_rel;
  int wr_q[$];
  int addr_q[$];
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mem_wr_en) begin wr_cnt++; wr_q.push_back(int'(bus.mem_addr)); end
      if (bus.busy) busy_cnt++;
      if (bus.done) begin done_cnt++; done_rel = cyc - t0 + 1; end
      if (bus.busy && !bus.done) addr_q.push_back(int'(bus.mem_addr));
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_mon();
    wr_cnt = 0; busy_cnt = 0; done_cnt = 0; done_rel = -1;
    wr_q.delete(); addr_q.delete();
  endtask

  // Issue one start strobe. When repulse is set, strobe start again so that
  // it is sampled at edge 3, while the engine is busy.
  task automatic issue(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                       input bit repulse);
    clr_mon();
    @(negedge clk);
    bus.start = 1'b1; bus.src_addr = s; bus.dst_addr = d; bus.len = l;
    @(posedge clk); #1;
    t0 = cyc;
    bus.start = 1'b0;
    if (repulse) begin
      repeat (3) @(negedge clk);
      bus.start = 1'b1; bus.src_addr = 8'h00; bus.dst_addr = 8'h00; bus.len = 8'd1;
      @(negedge clk);
      bus.start = 1'b0;
    end
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!bus.busy) break;
    end
    chk({tag, "_timeout"}, bus.busy, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0; bus.src_addr = '0; bus.dst_addr = '0; bus.len = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    clr_mon();
    t0 = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_wr_en", bus.mem_wr_en, 1'b0);
    chk("rst_addr", bus.mem_addr, 8'h00);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy", bus.busy, 1'b0);
    chk("idle_done_cnt", done_cnt, 0);

    // Basic copy: 10..13 -> 100..103
    mem[10] = 8'hA1; mem[11] = 8'hB2; mem[12] = 8'hC3; mem[13] = 8'hD4;
    issue(8'd10, 8'd100, 8'd4, 1'b0);
    wait_idle("basic");
    chk("basic_wr_cnt", wr_cnt, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("basic_wr_addr%0d", i), wr_q[i], 100 + i);
    chk("basic_m100", mem[100], 8'hA1);
    chk("basic_m101", mem[101], 8'hB2);
    chk("basic_m102", mem[102], 8'hC3);
    chk("basic_m103", mem[103], 8'hD4);
    chk("basic_done_cnt", done_cnt, 1);
    chk("basic_done_cycle", done_rel, 9);
    chk("basic_busy_cycles", busy_cnt, 9);

    // len = 0: DONE in the first cycle, no writes
    mem[5] = 8'h55; mem[6] = 8'h66;
    issue(8'd5, 8'd6, 8'd0, 1'b0);
    wait_idle("len0");
    chk("len0_wr_cnt", wr_cnt, 0);
    chk("len0_done_cnt", done_cnt, 1);
    chk("len0_done_cycle", done_rel, 1);
    chk("len0_m6", mem[6], 8'h66);

    // Address wrap: 254,255,0 -> 253,254,255
    mem[254] = 8'h11; mem[255] = 8'h22; mem[0] = 8'h33;
    issue(8'd254, 8'd253, 8'd3, 1'b0);
    wait_idle("wrap");
    chk("wrap_m253", mem[253], 8'h11);
    chk("wrap_m254", mem[254], 8'h22);
    chk("wrap_m255", mem[255], 8'h33);
    chk("wrap_seq_len", addr_q.size(), 6);
    chk("wrap_seq0", addr_q[0], 254);
    chk("wrap_seq1", addr_q[1], 253);
    chk("wrap_seq2", addr_q[2], 255);
    chk("wrap_seq3", addr_q[3], 254);
    chk("wrap_seq4", addr_q[4], 0);
    chk("wrap_seq5", addr_q[5], 255);

    // Start while busy is ignored
    for (int i = 0; i < 8; i++) mem[40 + i] = 8'h50 + 8'(i);
    issue(8'd40, 8'd140, 8'd8, 1'b1);
    wait_idle("busy");
    chk("busy_wr_cnt", wr_cnt, 8);
    chk("busy_done_cnt", done_cnt, 1);
    chk("busy_first_wr", wr_q[0], 140);
    chk("busy_last_wr", wr_q[7], 147);
    chk("busy_m147", mem[147], 8'h57);
    repeat (2) @(negedge clk);
    chk("busy_no_restart", bus.busy, 1'b0);

    // Abort with reset after three writes
    issue(8'd40, 8'd160, 8'd8, 1'b0);
    for (int i = 0; i < 50; i++) begin
      if (wr_cnt >= 3) break;
      @(negedge clk);
    end
    chk("abort_reach3", wr_cnt, 3);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_done", bus.done, 1'b0);
    chk("abort_wr_en", bus.mem_wr_en, 1'b0);
    chk("abort_addr", bus.mem_addr, 8'h00);
    chk("abort_m160", mem[160], 8'h50);
    chk("abort_m162", mem[162], 8'h52);
    chk("abort_m163", mem[163], 8'h00);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_no_done", done_cnt, 0);
    chk("abort_idle", bus.busy, 1'b0);

    // Overlap: 20..23 -> 21..24
    mem[20] = 8'd1; mem[21] = 8'd2; mem[22] = 8'd3; mem[23] = 8'd4; mem[24] = 8'd0;
    issue(8'd20, 8'd21, 8'd4, 1'b0);
    wait_idle("ovl");
`ifdef COPY_OVERLAP_SAFE_EN
    chk("ovl_first_wr", wr_q[0], 24);
    chk("ovl_m21", mem[21], 8'd1);
    chk("ovl_m22", mem[22], 8'd2);
    chk("ovl_m23", mem[23], 8'd3);
    chk("ovl_m24", mem[24], 8'd4);
`else
    chk("ovl_first_wr", wr_q[0], 21);
    chk("ovl_m21", mem[21], 8'd1);
    chk("ovl_m22", mem[22], 8'd1);
    chk("ovl_m23", mem[23], 8'd1);
    chk("ovl_m24", mem[24], 8'd1);
`endif
    chk("ovl_done_cycle", done_rel, 9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
